// File: rtl/tick_sched_pkg.sv
// -----------------------------------------------------------------------------
// tick_sched_pkg
// Shared definitions for the tick scheduler:
//   - state_t and the ST_* state constants (IDLE, RUN, RUN_PEND, STOPPING)
//   - CNT_W_DEF       : default divisor / counter width
//   - DEFAULT_DIV_DEF : divisor loaded at reset (half-period minus one)
//   - BURST_W         : width of the optional burst length
// -----------------------------------------------------------------------------
package tick_sched_pkg;

    localparam int CNT_W_DEF       = 25;
    localparam int DEFAULT_DIV_DEF = 24999999;
    localparam int BURST_W         = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_RUN      = 2'd1;
    localparam state_t ST_RUN_PEND = 2'd2;
    localparam state_t ST_STOPPING = 2'd3;

endpackage

// File: rtl/tick_counter.sv
// -----------------------------------------------------------------------------
// tick_counter
// Terminal-count divider core. Counts 0..div, then wraps. The wrap produces a
// registered one-cycle tick and toggles the divided clock in the same cycle.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   enable   in   count while high
//   clear    in   force cnt, tick and clk_div to zero
//   div      in   terminal count value
//   terminal out  combinational: counting and cnt==div (wrap on next edge)
//   tick     out  one-cycle pulse after each wrap
//   clk_div  out  square wave, toggles on each wrap
// -----------------------------------------------------------------------------
module tick_counter
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] div,
    output logic             terminal,
    output logic             tick,
    output logic             clk_div
);

    logic [CNT_W-1:0] cnt;

    assign terminal = enable && (cnt == div);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_div <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_div <= 1'b0;
        end else if (enable) begin
            if (cnt == div) begin
                // cnt never exceeds div, so the increment cannot overflow
                cnt     <= '0;
                tick    <= 1'b1;
                clk_div <= ~clk_div;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
// Runtime-programmable clock-enable scheduler. Produces a one-cycle tickOut at
// every terminal count and a 50% duty clockOut that toggles with each tick.
// Start, stop and divisor reload only take effect on period boundaries.
// Optional feature macro: TICK_SCHED_BURST_EN (adds burstIn, auto-stop after
// N completed clockOut periods; burstIn=0 free-runs).
// Ports:
//   clockIn   in   system clock, rising edge
//   resetN    in   asynchronous active-low reset
//   startIn   in   level, requests RUN from IDLE
//   stopIn    in   level, requests graceful stop (priority over start/reload)
//   divIn     in   new divisor (terminal count)
//   divValid  in   divIn valid; hold with divIn stable until accepted
//   divReady  out  divisor can be accepted this cycle (IDLE or RUN)
//   burstIn   in   [macro only] burst length, latched on IDLE->RUN
//   tickOut   out  one-cycle pulse per terminal count
//   clockOut  out  divided square wave
//   busyOut   out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
    input  logic               clockIn,
    input  logic               resetN,
    input  logic               startIn,
    input  logic               stopIn,
    input  logic [CNT_W-1:0]   divIn,
    input  logic               divValid,
    output logic               divReady,
`ifdef TICK_SCHED_BURST_EN
    input  logic [BURST_W-1:0] burstIn,
`endif
    output logic               tickOut,
    output logic               clockOut,
    output logic               busyOut
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] pend_div;
    logic             pend_valid;
    logic             terminal;
    logic             xfer;
    logic             fall;
    logic             burst_done;

    assign busyOut  = (state != ST_IDLE);
    assign divReady = (state == ST_IDLE) || (state == ST_RUN);
    assign xfer     = divValid && divReady;
    // Terminal count while clockOut is high: this edge drives clockOut 1->0,
    // closing a complete period.
    assign fall     = terminal && clockOut;

`ifdef TICK_SCHED_BURST_EN
    logic [BURST_W-1:0] burst_len;
    logic [BURST_W-1:0] burst_cnt;

    assign burst_done = (burst_len != '0) && fall &&
                        (burst_cnt == BURST_W'(burst_len - BURST_W'(1)));

    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            burst_len <= '0;
            burst_cnt <= '0;
        end else if (state == ST_IDLE) begin
            burst_cnt <= '0;
            if (state_nxt == ST_RUN) begin
                burst_len <= burstIn;
            end
        end else if (fall) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
        end
    end
`else
    assign burst_done = 1'b0;
`endif

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (startIn && !stopIn) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stopIn)    state_nxt = ST_STOPPING;
                else if (xfer) state_nxt = ST_RUN_PEND;
            end
            ST_RUN_PEND: begin
                if (stopIn)        state_nxt = ST_STOPPING;
                else if (terminal) state_nxt = ST_RUN;
            end
            ST_STOPPING: begin
                if (fall) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if ((state != ST_IDLE) && burst_done) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            div_reg    <= DEFAULT_DIV;
            pend_div   <= '0;
            pend_valid <= 1'b0;
        end else begin
            state <= state_nxt;

            // IDLE writes the divisor directly; otherwise a pending divisor
            // lands on a terminal count so the running period keeps its length.
            if ((state == ST_IDLE) && xfer) begin
                div_reg <= divIn;
            end else if (terminal && pend_valid) begin
                div_reg <= pend_div;
            end

            if ((state == ST_RUN) && xfer) begin
                pend_div <= divIn;
            end

            if (state_nxt == ST_IDLE) begin
                pend_valid <= 1'b0;
            end else if ((state == ST_RUN) && xfer) begin
                pend_valid <= 1'b1;
            end else if (terminal && pend_valid) begin
                pend_valid <= 1'b0;
            end
        end
    end

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clockIn),
        .rst_n    (resetN),
        .enable   (busyOut),
        .clear    (state == ST_IDLE),
        .div      (div_reg),
        .terminal (terminal),
        .tick     (tickOut),
        .clk_div  (clockOut)
    );

endmodule

// File: tb/tb_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tick_scheduler
// Scoreboard bench for tick_scheduler. A stimulus process drives inputs on the
// falling edge and steps a behavioural model (remaining-cycles countdown per
// period) that pushes the expected post-edge status and tick events into
// queues. A monitor pops and compares on the falling edge of each cycle.
// -----------------------------------------------------------------------------
module tb_tick_scheduler;

    localparam int             CW      = 25;
    localparam logic [CW-1:0]  DEF_DIV = 25'd24999999;

    logic          clockIn  = 1'b0;
    logic          resetN   = 1'b0;
    logic          startIn  = 1'b0;
    logic          stopIn   = 1'b0;
    logic          divValid = 1'b0;
    logic [CW-1:0] divIn    = '0;
    logic          divReady;
    logic          tickOut;
    logic          clockOut;
    logic          busyOut;
`ifdef TICK_SCHED_BURST_EN
    logic [15:0]   burstIn  = '0;
`endif

    tick_scheduler #(
        .CNT_W       (CW),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clockIn  (clockIn),
        .resetN   (resetN),
        .startIn  (startIn),
        .stopIn   (stopIn),
        .divIn    (divIn),
        .divValid (divValid),
        .divReady (divReady),
`ifdef TICK_SCHED_BURST_EN
        .burstIn  (burstIn),
`endif
        .tickOut  (tickOut),
        .clockOut (clockOut),
        .busyOut  (busyOut)
    );

    always #5 clockIn = ~clockIn;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    always @(posedge clockIn) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RUN, M_RUN_PEND, M_STOP} mode_e;
    typedef struct {
        int unsigned cyc;
        bit          clk;
        bit          busy;
        bit          ready;
    } status_t;
    typedef struct {
        int unsigned cyc;
        bit          clk;
    } tick_t;

    mode_e   m_mode;
    int      m_div;
    int      m_pend;
    bit      m_pend_v;
    int      m_left;   // cycles until the next terminal count
    bit      m_clk;
    status_t status_q[$];
    tick_t   tick_q[$];

    function automatic void model_reset();
        m_mode   = M_IDLE;
        m_div    = int'(DEF_DIV);
        m_pend   = 0;
        m_pend_v = 1'b0;
        m_left   = 0;
        m_clk    = 1'b0;
    endfunction

    // Predicts the outcome of the next rising edge given the inputs for it.
    function automatic bit model_step(bit s, bit p, bit v, int d);
        bit ready    = (m_mode == M_IDLE) || (m_mode == M_RUN);
        bit acc      = v && ready;
        bit tc       = 1'b0;
        bit was_high = m_clk;
        status_t st;
        tick_t   tk;
        if (m_mode != M_IDLE) begin
            m_left--;
            if (m_left == 0) begin
                tc    = 1'b1;
                m_clk = !m_clk;
                if (m_pend_v) begin
                    m_div    = m_pend;
                    m_pend_v = 1'b0;
                end
                m_left = m_div + 1;
            end
        end
        case (m_mode)
            M_IDLE: begin
                if (acc) m_div = d;
                if (s && !p) begin
                    m_mode = M_RUN;
                    m_left = m_div + 1;
                end
            end
            M_RUN: begin
                if (acc) begin
                    m_pend   = d;
                    m_pend_v = 1'b1;
                end
                if (p)        m_mode = M_STOP;
                else if (acc) m_mode = M_RUN_PEND;
            end
            M_RUN_PEND: begin
                if (p)       m_mode = M_STOP;
                else if (tc) m_mode = M_RUN;
            end
            M_STOP: begin
                if (tc && was_high) begin
                    m_mode   = M_IDLE;
                    m_pend_v = 1'b0;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        st.cyc   = cyc + 1;
        st.clk   = m_clk;
        st.busy  = (m_mode != M_IDLE);
        st.ready = (m_mode == M_IDLE) || (m_mode == M_RUN);
        status_q.push_back(st);
        if (tc) begin
            tk.cyc = cyc + 1;
            tk.clk = m_clk;
            tick_q.push_back(tk);
        end
        return acc;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clockIn) begin
        if (resetN) begin
            while (status_q.size() > 0 && status_q[0].cyc < cyc) void'(status_q.pop_front());
            while (tick_q.size() > 0 && tick_q[0].cyc < cyc) void'(tick_q.pop_front());
            if (status_q.size() > 0 && status_q[0].cyc == cyc) begin
                status_t st;
                st = status_q.pop_front();
                check("busyOut", busyOut, st.busy);
                check("divReady", divReady, st.ready);
                check("clockOut", clockOut, st.clk);
                if (tick_q.size() > 0 && tick_q[0].cyc == cyc) begin
                    tick_t tk;
                    tk = tick_q.pop_front();
                    check("tick_present", tickOut, 1);
                    check("tick_clock", clockOut, tk.clk);
                end else begin
                    check("tick_absent", tickOut, 0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit s, input bit p, input bit v, input int d, output bit acc);
        @(negedge clockIn);
        startIn  = s;
        stopIn   = p;
        divValid = v;
        divIn    = CW'(d);
        acc      = model_step(s, p, v, d);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, acc);
    endtask

    task automatic send_div(input int d);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 50) begin
            drive(1'b0, 1'b0, 1'b1, d, acc);
            n++;
        end
        if (!acc) check("send_div_timeout", n, 0);
        idle(1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (m_mode != M_IDLE && n < bound) begin
            idle(1);
            n++;
        end
        if (n >= bound) check("wait_idle_timeout", n, 0);
    endtask

    task automatic wait_model_clk(input bit level, input int bound);
        int n = 0;
        while (m_clk != level && n < bound) begin
            idle(1);
            n++;
        end
        if (n >= bound) check("wait_clk_timeout", n, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit acc;
        bit v_hold;
        int d_hold;

        model_reset();
        resetN = 1'b0;
        repeat (3) @(posedge clockIn);
        @(negedge clockIn);
        resetN = 1'b1;
        #1;
        check("rst_divReady", divReady, 1);
        check("rst_busyOut", busyOut, 0);
        check("rst_clockOut", clockOut, 0);
        check("rst_tickOut", tickOut, 0);
        check("rst_div_reg", dut.div_reg, DEF_DIV);

        // basic divide by 4 ticks per period
        send_div(3);
        drive(1'b1, 1'b0, 1'b0, 0, acc);
        idle(20);

        // reload mid-period to div=1
        idle(2);
        send_div(1);
        idle(16);

        // stop, then graceful stop with div=2 entered while clockOut=0
        drive(1'b0, 1'b1, 1'b0, 0, acc);
        wait_idle(200);
        send_div(2);
        drive(1'b1, 1'b0, 1'b0, 0, acc);
        wait_model_clk(1'b1, 20);
        wait_model_clk(1'b0, 20);
        drive(1'b0, 1'b1, 1'b0, 0, acc);
        wait_idle(100);
        @(posedge clockIn);
        #1;
        check("stop_busyOut", busyOut, 0);
        check("stop_cnt", dut.u_counter.cnt, 0);
        check("stop_clockOut", clockOut, 0);

        // start and stop together in IDLE: stays IDLE
        drive(1'b1, 1'b1, 1'b0, 0, acc);
        idle(3);

        // stop while a reload is pending
        drive(1'b1, 1'b0, 1'b0, 0, acc);
        idle(2);
        send_div(3);
        drive(1'b0, 1'b1, 1'b0, 0, acc);
        wait_idle(100);
        idle(2);

        // randomized traffic
        v_hold = 1'b0;
        d_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            bit s;
            bit p;
            s = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 39) == 0);
            if (!v_hold && $urandom_range(0, 5) == 0) begin
                v_hold = 1'b1;
                d_hold = int'($urandom_range(0, 4));
            end
            drive(s, p, v_hold, d_hold, acc);
            if (acc) v_hold = 1'b0;
        end
        drive(1'b0, 1'b1, 1'b0, 0, acc);
        wait_idle(200);

        // asynchronous reset mid-operation
        send_div(1);
        drive(1'b1, 1'b0, 1'b0, 0, acc);
        idle(5);
        @(posedge clockIn);
        #2;
        resetN = 1'b0;
        #1;
        status_q.delete();
        tick_q.delete();
        model_reset();
        check("midrst_busyOut", busyOut, 0);
        check("midrst_clockOut", clockOut, 0);
        check("midrst_tickOut", tickOut, 0);
        check("midrst_divReady", divReady, 1);
        check("midrst_div_reg", dut.div_reg, DEF_DIV);
        repeat (2) @(posedge clockIn);
        @(negedge clockIn);
        resetN = 1'b1;

        send_div(2);
        drive(1'b1, 1'b0, 1'b0, 0, acc);
        idle(10);
        drive(1'b0, 1'b1, 1'b0, 0, acc);
        wait_idle(100);
        idle(4);
        @(negedge clockIn);
        @(negedge clockIn);
        check("tick_queue_drained", tick_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
